mc_ctrl_fsm: RTL

Multi-cycle control unit that sits directly upstream of the execute-stage ALU. It decodes op/funct, sequences FETCH→DECODE→EXEC→MEM→WB, and drives the ALU `sel` code and all datapath enables. It handshakes with a variable-latency memory port, and raises a trap on ALU overflow (signed add/sub), illegal opcode, or memory timeout.

---
 rtl/mc_ctrl_fsm_pkg.sv | 92 +++++++++
 rtl/mc_decode.sv | 36 +++
 rtl/mc_ctrl_fsm.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: opcode/funct values,
// ALU select codes, datapath mux encodings, trap codes, FSM state constants
// and the decoded instruction class.
package mc_ctrl_fsm_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  // PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // ALU operand A select
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_RS = 1'b1;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Register file write-back source select
  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_LUI = 2'b10;

  // Trap cause codes
  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_OVF     = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  // FSM state encoding
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC_R = 4'd2;
  localparam logic [3:0] ST_EXEC_I = 4'd3;
  localparam logic [3:0] ST_ADDR   = 4'd4;
  localparam logic [3:0] ST_MEM_RD = 4'd5;
  localparam logic [3:0] ST_MEM_WR = 4'd6;
  localparam logic [3:0] ST_WB_R   = 4'd7;
  localparam logic [3:0] ST_WB_I   = 4'd8;
  localparam logic [3:0] ST_WB_MEM = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd12;

  // Decoded instruction class
  typedef enum logic [3:0] {
    CLS_ADDU,
    CLS_ADD,
    CLS_SUBU,
    CLS_SUB,
    CLS_ORI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_ILLEGAL
  } instr_class_t;

  // Only the signed forms trap on overflow; addu/subu silently wrap
  function automatic logic cls_traps_on_ovf(input instr_class_t cls);
    return (cls == CLS_ADD) || (cls == CLS_SUB);
  endfunction

  // Subtract forms drive the ALU with SUB, the add forms with ADD
  function automatic logic cls_is_sub(input instr_class_t cls);
    return (cls == CLS_SUB) || (cls == CLS_SUBU);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps op/funct onto an instruction
// class and flags anything outside the supported subset as illegal.
module mc_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t instr_class,
  output logic         illegal
);

  // Classify the instruction; funct only matters for the R-type opcode
  always_comb begin
    instr_class = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: instr_class = CLS_ADDU;
          FN_ADD:  instr_class = CLS_ADD;
          FN_SUBU: instr_class = CLS_SUBU;
          FN_SUB:  instr_class = CLS_SUB;
          default: instr_class = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:  instr_class = CLS_ORI;
      OP_LUI:  instr_class = CLS_LUI;
      OP_LW:   instr_class = CLS_LW;
      OP_SW:   instr_class = CLS_SW;
      OP_BEQ:  instr_class = CLS_BEQ;
      OP_J:    instr_class = CLS_J;
      default: instr_class = CLS_ILLEGAL;
    endcase
    illegal = (instr_class == CLS_ILLEGAL);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control unit feeding the execute-stage ALU. Sequences each
// instruction through fetch/decode/execute/memory/write-back, drives every
// datapath enable and mux select, waits on a variable-latency memory port
// and raises a one-cycle trap on signed overflow, illegal opcode or memory
// timeout. The trap cause stays visible on exc_code until the next trap.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic       reg_we,
  output logic       reg_dst,
  output logic [1:0] wb_sel,
  output logic       exc,
  output logic [1:0] exc_code
);

  // The wait counter is 8 bits wide, so only the low byte of the limit counts
  localparam logic [7:0] TIMEOUT_LIMIT = MEM_TIMEOUT[7:0];
  localparam logic       TIMEOUT_EN    = (MEM_TIMEOUT[7:0] != 8'd0);

  logic [3:0]   state;
  logic [3:0]   state_next;
  logic         active;
  logic [7:0]   wait_cnt;
  logic [7:0]   wait_cnt_inc;
  logic [1:0]   code_q;
  logic [1:0]   trap_code;
  instr_class_t cls_q;
  instr_class_t dec_class;
  logic         dec_illegal;
  logic         in_mem_state;
  logic         waiting;
  logic         timeout_hit;

  mc_decode u_decode (
    .op          (op),
    .funct       (funct),
    .instr_class (dec_class),
    .illegal     (dec_illegal)
  );

  // Memory-wait bookkeeping: a wait cycle is one where a request is
  // outstanding and the memory has not answered yet. The timeout fires on
  // the wait cycle that brings the count up to the limit, so a mem_ready
  // arriving in that very cycle still completes the access instead.
  always_comb begin
    in_mem_state = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
    waiting      = active && in_mem_state && !mem_ready;
    wait_cnt_inc = wait_cnt + 8'd1;
    timeout_hit  = TIMEOUT_EN && waiting && (wait_cnt_inc == TIMEOUT_LIMIT);
  end

  // Next-state selection plus the cause code to record when entering TRAP.
  // Nothing advances until the first clock edge after reset release.
  always_comb begin
    state_next = state;
    trap_code  = EXC_NONE;
    if (active) begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            state_next = ST_DECODE;
          end else if (timeout_hit) begin
            state_next = ST_TRAP;
            trap_code  = EXC_TIMEOUT;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            state_next = ST_TRAP;
            trap_code  = EXC_ILLEGAL;
          end else begin
            case (dec_class)
              CLS_ADDU, CLS_ADD, CLS_SUBU, CLS_SUB: state_next = ST_EXEC_R;
              CLS_ORI:        state_next = ST_EXEC_I;
              CLS_LUI:        state_next = ST_WB_I;
              CLS_LW, CLS_SW: state_next = ST_ADDR;
              CLS_BEQ:        state_next = ST_BRANCH;
              CLS_J:          state_next = ST_JUMP;
              default: begin
                state_next = ST_TRAP;
                trap_code  = EXC_ILLEGAL;
              end
            endcase
          end
        end
        ST_EXEC_R: begin
          if (cls_traps_on_ovf(cls_q) && alu_ovf) begin
            state_next = ST_TRAP;
            trap_code  = EXC_OVF;
          end else begin
            state_next = ST_WB_R;
          end
        end
        ST_EXEC_I: state_next = ST_WB_I;
        ST_ADDR:   state_next = (cls_q == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD: begin
          if (mem_ready) begin
            state_next = ST_WB_MEM;
          end else if (timeout_hit) begin
            state_next = ST_TRAP;
            trap_code  = EXC_TIMEOUT;
          end
        end
        ST_MEM_WR: begin
          if (mem_ready) begin
            state_next = ST_FETCH;
          end else if (timeout_hit) begin
            state_next = ST_TRAP;
            trap_code  = EXC_TIMEOUT;
          end
        end
        ST_WB_R, ST_WB_I, ST_WB_MEM: state_next = ST_FETCH;
        ST_BRANCH, ST_JUMP, ST_TRAP: state_next = ST_FETCH;
        default: state_next = ST_FETCH;
      endcase
    end
  end

  // Run flag: holds every output low while in reset and lets FETCH drive
  // the bus from the first clock edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
    end else begin
      active <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Memory wait counter: restarts on every state change and saturates so
  // a disabled timeout cannot wrap around into a false limit match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state_next != state) begin
      wait_cnt <= 8'd0;
    end else if (waiting && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt_inc;
    end
  end

  // Trap cause register, loaded on the edge that enters TRAP so the new
  // code is already visible alongside the exc pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= EXC_NONE;
    end else if (state_next == ST_TRAP) begin
      code_q <= trap_code;
    end
  end

  // Instruction class captured while leaving DECODE so later states do not
  // depend on the instruction register staying put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q <= CLS_ILLEGAL;
    end else if (active && (state == ST_DECODE)) begin
      cls_q <= dec_class;
    end
  end

  // Output decode: per-state datapath controls, with pc_we in BRANCH and
  // ir_we/pc_we in FETCH following the same-cycle inputs
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SRC_SEQ;
    alu_sel   = ALU_ADD;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RT;
    ext_sign  = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = WBSEL_ALU;
    exc       = 1'b0;
    exc_code  = code_q;
    if (active) begin
      case (state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          ext_sign  = 1'b1;
        end
        ST_EXEC_R: begin
          alu_src_a = SRCA_RS;
          alu_sel   = cls_is_sub(cls_q) ? ALU_SUB : ALU_ADD;
        end
        ST_EXEC_I: begin
          alu_src_a = SRCA_RS;
          alu_src_b = SRCB_IMM;
          alu_sel   = ALU_OR;
        end
        ST_ADDR: begin
          alu_src_a = SRCA_RS;
          alu_src_b = SRCB_IMM;
          ext_sign  = 1'b1;
        end
        ST_MEM_RD, ST_MEM_WR: begin
          mem_req   = 1'b1;
          mem_we    = (state == ST_MEM_WR);
          alu_src_a = SRCA_RS;
          alu_src_b = SRCB_IMM;
          ext_sign  = 1'b1;
        end
        ST_WB_R: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        ST_WB_I: begin
          reg_we = 1'b1;
          wb_sel = (cls_q == CLS_LUI) ? WBSEL_LUI : WBSEL_ALU;
        end
        ST_WB_MEM: begin
          reg_we = 1'b1;
          wb_sel = WBSEL_MEM;
        end
        ST_BRANCH: begin
          alu_src_a = SRCA_RS;
          alu_sel   = ALU_SUB;
          pc_src    = PC_SRC_BRANCH;
          pc_we     = alu_zero;
        end
        ST_JUMP: begin
          pc_we  = 1'b1;
          pc_src = PC_SRC_JUMP;
        end
        ST_TRAP: begin
          exc = 1'b1;
        end
        default: begin
          exc = 1'b0;
        end
      endcase
    end
  end

endmodule
